fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Drains a show-ahead FIFO (one-cycle-delayed write commit, combinational `q`, `rdreq`/`empty` handshake) and serializes each word as one or more 8N1 UART frames on a single TX line. It sits on the read side of a processor output FIFO. The processor pushes words at core speed; this block pops them one at a time and shifts them out at the configured bit rate. Each word is sent as `WORD/8` bytes, least-significant byte first.

## Interface
- `WORD`, 16: FIFO word width. Must be a multiple of 8, at least 8.
- `DIV`, 434: clock cycles per UART bit. Must be at least 2.
- `clock`  in  1  single clock, rising edge.
- `sclr`  in  1  synchronous, active-high reset.
- `enable`  in  1  permits starting a new word; sampled only in IDLE.
- `fifo_q`  in  WORD  FIFO head word (show-ahead).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rdreq`  out  1  pop request, one cycle per word.
- `tx`  out  1  serial line, idles high, registered.
- `busy`  out  1  high from LOAD until the last stop bit ends.

## Operation
- States: IDLE, LOAD, START, DATA, STOP.
- **IDLE:**
  - `tx`=1, `busy`=0.
  - If `enable & ~fifo_empty`, go to LOAD. No pop happens here: a freshly deasserted `empty` may precede the FIFO memory write by one cycle.
- **LOAD** (one cycle):
  - Capture `fifo_q` into the WORD-bit shift register.
  - Drive `fifo_rdreq`=1 combinationally in this state only.
  - Clear the byte counter.
  - Go to START.
- **START:**
  - `tx`=0 for DIV cycles.
  - Then go to DATA with the bit counter at 0.
- **DATA:**
  - `tx` = `shreg[0]` for DIV cycles per bit.
  - Shift the register right by 1 at each bit boundary.
  - After 8 bits, go to STOP.
- **STOP:**
  - `tx`=1 for DIV cycles.
  - Then, if byte counter = `WORD/8-1`, go to IDLE.
  - Otherwise increment the byte counter and go to START.
- **Baud counter:**
  - Width is `$clog2(DIV)`. Cleared on every state entry.
  - A bit boundary is reached when the counter equals DIV-1.
- **Other counters:** bit counter is 3 bits; byte counter is `$clog2(WORD/8)` bits, with a minimum of 1.
- **Reset values:** `tx`=1, `busy`=0, `fifo_rdreq`=0, state=IDLE, all counters 0.
- **Boundary conditions:**
  - `sclr` mid-frame: `tx`=1 the next cycle. The current word is lost, since it was already popped. No partial-frame completion.
  - `enable` low mid-word: the word finishes; no new LOAD is entered.
  - `fifo_empty` rising while in START/DATA/STOP: no effect.
  - `fifo_rdreq` is never asserted while `fifo_empty`=1. It is at most one pulse per word.

## Timing
- **Start latency:** `fifo_empty` falls in cycle t (`enable`=1, IDLE). LOAD is in t+1, with the pop taking effect at the t+1 edge. The START bit begins driving `tx`=0 in cycle t+2.
- **Frame length:** 10·DIV cycles per byte, so a word takes `10·DIV·WORD/8` cycles from the START entry.
- **Back-to-back words:** STOP end, then IDLE (1 cycle), then LOAD (1 cycle), then START. This gives a stop-to-start line-high gap of DIV+2 cycles.
- **Bytes within a word:** exactly one stop bit (DIV cycles) between them.
- **`busy`:** rises with LOAD and falls on entry to IDLE.

## Structure
- Shared package `sapho_uart_pkg`:
  - state encoding localparams (3-bit);
  - UART frame constants (`DATA_BITS`=8, `STOP_BITS`=1).
- Sub-module `baud_tick`: DIV-cycle counter with synchronous `clr` and a `tick` output. It is reusable by the future receiver.
- Top-level FSM, shift register and byte/bit counters stay in `fifo_uart_tx`.

## Test plan
Use DIV=4, WORD=16 unless noted.
- **Reset state:** hold `sclr`. Require `tx`=1, `busy`=0, `fifo_rdreq`=0 for every cycle, including with `fifo_empty`=0.
- **Single word:** push 0xA55A.
  - One `fifo_rdreq` pulse, in the LOAD cycle.
  - `tx` bit sequence 0,0101 1010,1 then 0,1010 0101,1. Each bit is 4 cycles; 80 cycles in total.
  - `busy` falls afterwards.
- **Late-write safety:** drive `fifo_empty` low one cycle before `fifo_q` becomes valid. Capture must use the LOAD-cycle value and no stale data may be sent.
- **Back-to-back:** push 0x0001 and 0xFFFF together.
  - Exactly 2 pops.
  - Gap between the last stop bit and the next start bit is 6 cycles.
  - Second word bits are all 1s between the start bits.
- **Reset mid-DATA:** assert `sclr` in bit 3 of byte 0.
  - `tx`=1 the next cycle, IDLE.
  - After release with the FIFO still non-empty, the next word starts cleanly with no extra pop.
- **`enable` gating:** deassert `enable` mid-word with 3 words queued. The current word completes, no further `fifo_rdreq` occurs, and the remaining words resume on re-enable.

Source files
------------

// File: rtl/sapho_uart_pkg.sv
// rtl/sapho_uart_pkg.sv - shared UART state encoding and frame constants
package sapho_uart_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

endpackage

// File: rtl/baud_tick.sv
// rtl/baud_tick.sv - free-running DIV-cycle bit timer with synchronous clear
module baud_tick #(
    parameter int DIV = 434
) (
    input  logic clock,
    input  logic sclr,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clock) begin
        if (sclr || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops show-ahead FIFO words and sends them LSB byte first as 8N1 frames
module fifo_uart_tx
    import sapho_uart_pkg::*;
#(
    parameter int WORD = 16,
    parameter int DIV  = 434
) (
    input  logic            clock,
    input  logic            sclr,
    input  logic            enable,
    input  logic [WORD-1:0] fifo_q,
    input  logic            fifo_empty,
    output logic            fifo_rdreq,
    output logic            tx,
    output logic            busy
);

    localparam int NBYTES = WORD / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);

    logic [2:0]      state, state_n;
    logic [WORD-1:0] shreg, shreg_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [BW-1:0]   byte_cnt, byte_n;
    logic            tx_n;
    logic            tick;
    logic            baud_clr;

    // Every state change restarts the bit timer so each phase lasts exactly DIV cycles.
    assign baud_clr = (state_n != state);

    baud_tick #(.DIV(DIV)) u_baud (
        .clock (clock),
        .sclr  (sclr),
        .clr   (baud_clr),
        .tick  (tick)
    );

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        bit_n   = bit_cnt;
        byte_n  = byte_cnt;
        case (state)
            S_IDLE: begin
                // No pop here: the FIFO word may land one cycle after empty drops.
                if (enable && !fifo_empty) begin
                    state_n = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_n = fifo_q;
                byte_n  = '0;
                bit_n   = '0;
                state_n = S_START;
            end
            S_START: begin
                if (tick) begin
                    bit_n   = '0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shreg_n = shreg >> 1;
                    if (bit_cnt == LAST_DATA) begin
                        bit_n   = '0;
                        state_n = S_STOP;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_n = '0;
                        if (byte_cnt == LAST_BYTE) begin
                            state_n = S_IDLE;
                        end else begin
                            byte_n  = byte_cnt + 1'b1;
                            state_n = S_START;
                        end
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // tx is registered from the next state so the line changes together with the state.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            S_START: tx_n = 1'b0;
            S_DATA:  tx_n = shreg_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (sclr) begin
            state    <= S_IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_n;
            byte_cnt <= byte_n;
            tx       <= tx_n;
        end
    end

    assign fifo_rdreq = (state == S_LOAD);
    assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - self-checking bench for fifo_uart_tx against a frame-level reference
module tb_fifo_uart_tx;

    localparam int DIV   = 4;
    localparam int WORD  = 16;
    localparam int NB    = WORD / 8;
    localparam int FRAME = 10 * DIV * NB;
    localparam int SLOT  = FRAME + 2;

    logic            clock = 1'b0;
    logic            sclr;
    logic            enable;
    logic [WORD-1:0] fifo_q;
    logic            fifo_empty;
    logic            fifo_rdreq;
    logic            tx;
    logic            busy;

    int              vectors = 0;
    int              miscompares = 0;
    int              pops = 0;
    logic [WORD-1:0] fq[$];
    bit              hide = 1'b0;

    fifo_uart_tx #(.WORD(WORD), .DIV(DIV)) dut (
        .clock      (clock),
        .sclr       (sclr),
        .enable     (enable),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Line level per cycle for one word slot: IDLE, LOAD, then NB frames of start/8 data/stop.
    function automatic logic [SLOT-1:0] exp_word_trace(input logic [WORD-1:0] w);
        logic [SLOT-1:0] v;
        int c, by, pos;
        v = '1;
        for (int j = 2; j < SLOT; j++) begin
            c   = j - 2;
            by  = c / (10 * DIV);
            pos = (c % (10 * DIV)) / DIV;
            if (pos == 0)      v[j] = 1'b0;
            else if (pos == 9) v[j] = 1'b1;
            else               v[j] = w[8 * by + pos - 1];
        end
        return v;
    endfunction

    task automatic drive_fifo();
        fifo_empty = (fq.size() == 0);
        if (fq.size() == 0)
            fifo_q = WORD'($urandom);
        else if (hide)
            fifo_q = ~fq[0];
        else
            fifo_q = fq[0];
    endtask

    task automatic step();
        logic rd;
        rd = fifo_rdreq;
        vectors++;
        if (rd && fifo_empty) begin
            miscompares++;
            $display("FAIL rdreq_while_empty: rdreq=%b empty=%b, required empty=0", rd, fifo_empty);
        end
        @(posedge clock);
        #1;
        if (rd && fq.size() > 0) begin
            fq.delete(0);
            pops++;
        end
        hide = 1'b0;
        drive_fifo();
    endtask

    // Starts in an IDLE cycle with data visible and enable high.
    task automatic expect_words(input logic [WORD-1:0] ws[$], input string name);
        logic [SLOT-1:0] atx, abusy, ard, etx, ebusy, erd;
        int p0, bad;
        p0 = pops;
        for (int k = 0; k < ws.size(); k++) begin
            for (int j = 0; j < SLOT; j++) begin
                atx[j]   = tx;
                abusy[j] = busy;
                ard[j]   = fifo_rdreq;
                step();
            end
            etx   = exp_word_trace(ws[k]);
            ebusy = '1;
            ebusy[0] = 1'b0;
            erd   = '0;
            erd[1] = 1'b1;
            vectors++;
            if (atx !== etx) begin
                miscompares++;
                $display("FAIL %s_tx word%0d: got %h, required %h", name, k, atx, etx);
            end
            vectors++;
            if (abusy !== ebusy) begin
                miscompares++;
                $display("FAIL %s_busy word%0d: got %h, required %h", name, k, abusy, ebusy);
            end
            vectors++;
            if (ard !== erd) begin
                miscompares++;
                $display("FAIL %s_rdreq word%0d: got %h, required %h", name, k, ard, erd);
            end
        end
        bad = 0;
        for (int j = 0; j < 4; j++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rdreq !== 1'b0) bad++;
            step();
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s_idle_after: %0d non-idle cycles, required 0", name, bad);
        end
        vectors++;
        if (pops - p0 != ws.size()) begin
            miscompares++;
            $display("FAIL %s_pops: got %0d, required %0d", name, pops - p0, ws.size());
        end
    endtask

    task automatic test_reset();
        sclr   = 1'b1;
        enable = 1'b1;
        fq.push_back(16'h1234);
        drive_fifo();
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rdreq !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state cyc%0d: tx=%b busy=%b rdreq=%b, required 1 0 0",
                         i, tx, busy, fifo_rdreq);
            end
            step();
        end
        fq.delete();
        drive_fifo();
        sclr = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_single_word();
        logic [WORD-1:0] ws[$];
        ws.push_back(16'hA55A);
        fq.push_back(16'hA55A);
        drive_fifo();
        expect_words(ws, "single_a55a");
        ws.delete();
        ws.push_back(WORD'($urandom));
        fq.push_back(ws[0]);
        drive_fifo();
        expect_words(ws, "single_rand");
    endtask

    task automatic test_late_write();
        logic [WORD-1:0] ws[$];
        ws.push_back(WORD'($urandom));
        fq.push_back(ws[0]);
        hide = 1'b1;
        drive_fifo();
        expect_words(ws, "late_write");
    endtask

    task automatic test_back_to_back();
        logic [WORD-1:0] ws[$];
        ws.push_back(16'h0001);
        ws.push_back(16'hFFFF);
        foreach (ws[i]) fq.push_back(ws[i]);
        drive_fifo();
        expect_words(ws, "b2b_fixed");
        ws.delete();
        for (int i = 0; i < 4; i++) ws.push_back(WORD'($urandom));
        foreach (ws[i]) fq.push_back(ws[i]);
        drive_fifo();
        expect_words(ws, "b2b_rand");
    endtask

    task automatic test_reset_mid_data();
        logic [WORD-1:0] w0;
        logic [WORD-1:0] ws[$];
        int p0;
        w0 = WORD'($urandom);
        ws.push_back(WORD'($urandom));
        fq.push_back(w0);
        fq.push_back(ws[0]);
        drive_fifo();
        p0 = pops;
        for (int j = 0; j < 19; j++) begin
            if (j == 18) begin
                vectors++;
                if (tx !== w0[3]) begin
                    miscompares++;
                    $display("FAIL midreset_bit3: tx=%b, required %b", tx, w0[3]);
                end
            end
            step();
        end
        sclr = 1'b1;
        step();
        sclr = 1'b0;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || fifo_rdreq !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_after: tx=%b busy=%b rdreq=%b, required 1 0 0", tx, busy, fifo_rdreq);
        end
        vectors++;
        if (pops - p0 != 1) begin
            miscompares++;
            $display("FAIL midreset_pops: got %0d, required 1", pops - p0);
        end
        expect_words(ws, "midreset_resume");
    endtask

    task automatic test_enable_gating();
        logic [WORD-1:0] w0;
        logic [WORD-1:0] ws[$];
        logic [SLOT-1:0] atx, etx;
        int p0, active;
        w0 = WORD'($urandom);
        ws.push_back(WORD'($urandom));
        ws.push_back(WORD'($urandom));
        fq.push_back(w0);
        foreach (ws[i]) fq.push_back(ws[i]);
        enable = 1'b1;
        drive_fifo();
        p0 = pops;
        for (int j = 0; j < SLOT; j++) begin
            atx[j] = tx;
            if (j == 30) enable = 1'b0;
            step();
        end
        etx = exp_word_trace(w0);
        vectors++;
        if (atx !== etx) begin
            miscompares++;
            $display("FAIL gate_first_word: got %h, required %h", atx, etx);
        end
        active = 0;
        for (int j = 0; j < 40; j++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_rdreq !== 1'b0) active++;
            step();
        end
        vectors++;
        if (active != 0) begin
            miscompares++;
            $display("FAIL gate_hold_idle: %0d active cycles, required 0", active);
        end
        vectors++;
        if (pops - p0 != 1) begin
            miscompares++;
            $display("FAIL gate_pops: got %0d, required 1", pops - p0);
        end
        enable = 1'b1;
        expect_words(ws, "gate_resume");
    endtask

    initial begin
        sclr   = 1'b1;
        enable = 1'b0;
        drive_fifo();
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_single_word();
        test_late_write();
        test_back_to_back();
        test_reset_mid_data();
        test_enable_gating();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
